vga_draw_arbiter: RTL and testbench

Shares the single VGA pixel-write port (x, y, colour, writeEn) between NUM_REQ UI drawing units, such as the screen-clear unit and the shape/arrow drawers.
- Each drawer raises req and waits for grant. It then drives its pixel stream and pulses done.
- The arbiter holds ownership for the whole drawing, selects the next owner round-robin, and registers the muxed pixel stream toward the VGA adapter.
- It sits between the per-shape control/datapath pairs and the VGA adapter instance.

---
 rtl/draw_arb_pkg.sv | 20 ++
 rtl/rr_picker.sv | 24 ++
 rtl/vga_draw_arbiter.sv | 127 ++++++++++++
 tb/tb_vga_draw_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/draw_arb_pkg.sv
// Shared encodings and widths for the VGA draw arbiter.
package draw_arb_pkg;

    // Arbiter FSM states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_DRAW    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    // VGA pixel field widths
    localparam int X_W = 8;
    localparam int Y_W = 7;
    localparam int C_W = 3;

    // Screen-clear unit defaults
    localparam logic [C_W-1:0] CLR_COLOR = 3'b111;
    localparam logic [X_W-1:0] CLR_X     = 8'd72;
    localparam logic [Y_W-1:0] CLR_Y     = 7'd55;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first requester with req set,
// scanning upward from last+1 with wrap-around.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int OWN_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [OWN_W-1:0]   last,
    output logic [OWN_W-1:0]   winner,
    output logic               valid
);

    // Scan from farthest to nearest so the nearest set request wins
    always_comb begin
        winner = last;
        valid  = |req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NUM_REQ]) begin
                winner = OWN_W'((int'(last) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/vga_draw_arbiter.sv
// Round-robin owner of the single VGA pixel-write port shared by the UI
// drawing units. Ownership lasts for a whole drawing and the muxed pixel
// stream is registered toward the VGA adapter.
// Optional watchdog: define DRAW_ARB_TIMEOUT_EN to revoke a grant after
// TIMEOUT_CYCLES DRAW cycles without done.
module vga_draw_arbiter
    import draw_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int OWN_W          = 2,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     done,
    input  logic [NUM_REQ-1:0]     wr_en_in,
    input  logic [NUM_REQ*X_W-1:0] x_in,
    input  logic [NUM_REQ*Y_W-1:0] y_in,
    input  logic [NUM_REQ*C_W-1:0] color_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic [OWN_W-1:0]       owner,
    output logic                   busy,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         color,
    output logic                   writeEn,
    output logic                   timeout
);

    logic [1:0]       state;
    logic [OWN_W-1:0] winner;
    logic             win_vld;
    logic             end_draw;
    logic             wd_hit;
    logic             release_now;
    logic             draw_wr;

    // owner doubles as the round-robin pointer
    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .OWN_W   (OWN_W)
    ) u_rr_picker (
        .req    (req),
        .last   (owner),
        .winner (winner),
        .valid  (win_vld)
    );

    assign end_draw    = done[owner] | ~req[owner];
    assign release_now = (state == ST_DRAW) & (end_draw | wd_hit);
    assign draw_wr     = (state == ST_DRAW) & wr_en_in[owner];

`ifdef DRAW_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES);
    logic [WD_W-1:0] watchdog;

    // Count DRAW cycles of the current grant; cleared while in GRANT
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            watchdog <= '0;
        end else if (state == ST_GRANT) begin
            watchdog <= '0;
        end else if (state == ST_DRAW) begin
            watchdog <= watchdog + 1'b1;
        end
    end

    assign wd_hit  = (state == ST_DRAW) && (watchdog == WD_W'(TIMEOUT_CYCLES - 1));
    assign timeout = wd_hit & ~end_draw;
`else
    assign wd_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // Ownership FSM: IDLE -> GRANT -> DRAW -> RELEASE -> IDLE
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            grant <= '0;
            owner <= OWN_W'(NUM_REQ - 1);
            busy  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (win_vld) begin
                        owner <= winner;
                        grant <= NUM_REQ'(1) << winner;
                        busy  <= 1'b1;
                        state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    state <= ST_DRAW;
                end
                ST_DRAW: begin
                    if (release_now) begin
                        grant <= '0;
                        busy  <= 1'b0;
                        state <= ST_RELEASE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Registered pixel path; coordinates and colour hold between writes
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            writeEn <= 1'b0;
            x       <= '0;
            y       <= '0;
            color   <= '0;
        end else begin
            writeEn <= draw_wr;
            if (draw_wr) begin
                x     <= x_in[int'(owner)*X_W +: X_W];
                y     <= y_in[int'(owner)*Y_W +: Y_W];
                color <= color_in[int'(owner)*C_W +: C_W];
            end
        end
    end

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Randomized self-checking bench for vga_draw_arbiter against a
// transaction-style reference model of ownership and the pixel stream.
module tb_vga_draw_arbiter;

    localparam int N   = 4;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [N-1:0]  req, done, wr_en_in;
    logic [N*8-1:0] x_in;
    logic [N*7-1:0] y_in;
    logic [N*3-1:0] color_in;
    logic [N-1:0]  grant;
    logic [1:0]    owner;
    logic          busy;
    logic [7:0]    x;
    logic [6:0]    y;
    logic [2:0]    color;
    logic          writeEn;
    logic          timeout;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    vga_draw_arbiter #(
        .NUM_REQ        (N),
        .OWN_W          (2),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req      (req),
        .done     (done),
        .wr_en_in (wr_en_in),
        .x_in     (x_in),
        .y_in     (y_in),
        .color_in (color_in),
        .grant    (grant),
        .owner    (owner),
        .busy     (busy),
        .x        (x),
        .y        (y),
        .color    (color),
        .writeEn  (writeEn),
        .timeout  (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: ownership seen as "held for age cycles", then a gap
    bit   m_active;
    int   m_age;      // 0 = grant cycle, >=1 = n-th drawing cycle
    bit   m_gap;
    int   m_owner;
    bit   m_we;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_c;

    function automatic int rr_pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (r[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    function automatic bit exp_timeout();
`ifdef DRAW_ARB_TIMEOUT_EN
        return m_active && m_age == TMO && req[m_owner] && !done[m_owner];
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        m_active = 0; m_age = 0; m_gap = 0; m_owner = N - 1;
        m_we = 0; m_x = '0; m_y = '0; m_c = '0;
    endtask

    task automatic model_step();
        bit drawing, tmo, wr;
        int w;
        if (!reset_n) begin
            model_reset();
            return;
        end
        drawing = m_active && m_age >= 1;
        tmo     = exp_timeout();
        wr      = drawing && wr_en_in[m_owner];
        m_we    = wr;
        if (wr) begin
            m_x = x_in[m_owner*8 +: 8];
            m_y = y_in[m_owner*7 +: 7];
            m_c = color_in[m_owner*3 +: 3];
        end
        if (drawing) begin
            if (done[m_owner] || !req[m_owner] || tmo) begin
                m_active = 0;
                m_gap    = 1;
            end else begin
                m_age++;
            end
        end else if (m_active) begin
            m_age = 1;
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            w = rr_pick(req, m_owner);
            if (w >= 0) begin
                m_owner  = w;
                m_active = 1;
                m_age    = 0;
            end
        end
    endtask

    task automatic drive_random();
        reset_n = (cyc < 3 || $urandom_range(299) == 0) ? 1'b0 : 1'b1;
        done = '0;
        for (int i = 0; i < N; i++) begin
            if (!req[i]) begin
                req[i] = ($urandom_range(3) == 0);
            end else if (m_active && i == m_owner && $urandom_range(9) == 0) begin
                done[i] = 1'b1;
                req[i]  = $urandom_range(1);
            end else if ($urandom_range(59) == 0) begin
                req[i] = 1'b0;
            end
            if (i != m_owner && $urandom_range(19) == 0) done[i] = 1'b1;
        end
        wr_en_in = N'($urandom);
        x_in     = 32'($urandom);
        y_in     = 28'($urandom);
        color_in = 12'($urandom);
    endtask

    task automatic drive_hold();
        // single requester that never finishes: grant must stay (or time out)
        reset_n  = (cyc == 2000) ? 1'b0 : 1'b1;
        req      = 4'b0001;
        done     = '0;
        wr_en_in = N'($urandom);
        x_in     = 32'($urandom);
        y_in     = 28'($urandom);
        color_in = 12'($urandom);
    endtask

    initial begin
        req = '0; done = '0; wr_en_in = '0; reset_n = 1'b0;
        x_in = '0; y_in = '0; color_in = '0;
        model_reset();
        for (cyc = 0; cyc < 2300; cyc++) begin
            @(negedge clk);
            if (cyc < 2000) drive_random();
            else            drive_hold();
            #1;
            if (cyc >= 1) begin
                chk("grant",   32'(grant),   m_active ? 32'(1) << m_owner : 32'd0);
                chk("owner",   32'(owner),   32'(m_owner));
                chk("busy",    32'(busy),    32'(m_active));
                chk("writeEn", 32'(writeEn), 32'(m_we));
                chk("x",       32'(x),       32'(m_x));
                chk("y",       32'(y),       32'(m_y));
                chk("color",   32'(color),   32'(m_c));
                chk("timeout", 32'(timeout), 32'(exp_timeout()));
            end
            model_step();
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
